// File: rtl/counter_4bit.sv
// counter_4bit: free-running modulo-2^WIDTH up-counter with synchronous clear,
// built from one clear-dominant toggle cell per bit and an AND-ripple carry chain.
`default_nettype none

module counter_4bit #(
  parameter int WIDTH = 4
) (
  output logic [WIDTH-1:0] Q,
  input  logic             clk,
  input  logic             clr
);

  // carry[i] is high when bits 0..i-1 are all 1, i.e. bit i toggles on a count edge
  logic [WIDTH-1:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic state;

    // Written as an AND rather than an if/else so an unknown clr only corrupts
    // bits whose count and clear outcomes disagree (those that would become 1).
    always_ff @(posedge clk) begin
      state <= ~clr & (state ^ carry[i]);
    end

    assign Q[i] = state;

    if (i < WIDTH - 1) begin : g_carry
      assign carry[i+1] = carry[i] & state;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_counter_4bit.sv
// tb_counter_4bit: randomized and directed check of counter_4bit at WIDTH 4, 1 and 8
// against an integer modulo-2^WIDTH reference model.
`default_nettype none

module tb_counter_4bit;

  logic       clk;
  logic       clr;
  logic [3:0] q4;
  logic [0:0] q1;
  logic [7:0] q8;

  int n_cmp;
  int n_bad;

  // reference model state: plain integer counts
  int  m4, m1, m8;
  bit  model_valid;

  counter_4bit #(.WIDTH(4)) dut4 (.Q(q4), .clk(clk), .clr(clr));
  counter_4bit #(.WIDTH(1)) dut1 (.Q(q1), .clk(clk), .clr(clr));
  counter_4bit #(.WIDTH(8)) dut8 (.Q(q8), .clk(clk), .clr(clr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model on a rising edge with the given clear value.
  task automatic model_edge(input bit c);
    if (c) begin
      m4 = 0; m1 = 0; m8 = 0;
      model_valid = 1'b1;
    end else begin
      m4 = (m4 + 1) % 16;
      m1 = (m1 + 1) % 2;
      m8 = (m8 + 1) % 256;
    end
  endtask

  task automatic compare_all(input string tag);
    if (model_valid) begin
      check({tag, "_w4"}, int'(q4), m4);
      check({tag, "_w1"}, int'(q1), m1);
      check({tag, "_w8"}, int'(q8), m8);
    end
  endtask

  // One clock cycle: drive clr after the falling edge, optionally pulse clr
  // high between edges without covering the rising edge, then check after the edge.
  task automatic step(input bit c, input bit glitch, input string tag);
    @(negedge clk);
    clr = c;
    if (glitch) begin
      #1 clr = 1'b1;
      #2 clr = c;
    end
    @(posedge clk);
    model_edge(c);
    #1 compare_all(tag);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m4 = 0; m1 = 0; m8 = 0;
    model_valid = 1'b0;

    // Clear held over the first rising edge at 5 ns.
    clr = 1'b1;
    @(posedge clk);
    model_edge(1'b1);
    #1 compare_all("reset");
    check("reset_q4_zero", int'(q4), 0);

    // Release: 1, 2, then continue through the wrap and beyond.
    step(1'b0, 1'b0, "first_count");
    check("first_count_is_1", int'(q4), 1);
    for (int i = 0; i < 19; i++) step(1'b0, 1'b0, "run");
    check("after_20_edges", int'(q4), 4);

    // Reach 9, hold clear for three edges, then resume.
    for (int i = 0; i < 16 && m4 != 9; i++) step(1'b0, 1'b0, "to9");
    check("reached_9", int'(q4), 9);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "hold_clr");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "resume");
    check("resume_3", int'(q4), 3);

    // Clear on the wrap edge wins over the wrap.
    for (int i = 0; i < 16 && m4 != 15; i++) step(1'b0, 1'b0, "to15");
    check("reached_15", int'(q4), 15);
    step(1'b1, 1'b0, "clr_on_wrap");
    check("clr_on_wrap_zero", int'(q4), 0);

    // Clear pulses between edges must not affect Q.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, "glitch");
    check("glitch_count", int'(q4), 4);

    // Natural wrap of the 8-bit instance and long random run.
    step(1'b1, 1'b0, "pre_w8_wrap");
    for (int i = 0; i < 258; i++) step(1'b0, 1'b0, "w8_wrap");
    check("w8_after_258", int'(q8), 2);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
